// File: rtl/mult_colseq_driver.sv
// rtl/mult_colseq_driver.sv - column-serial unsigned multiplier driving an external 6:3 column counter
// Optional consistency checker enabled by defining MULT_COLSEQ_CHECK_EN.
module mult_colseq_driver #(
    parameter int W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic [5:0]       cnt_a,
    input  logic [2:0]       cnt_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic             chk_err
);

    localparam int CW = $clog2(2 * W);
    localparam logic [CW-1:0] COL_LAST = CW'(2 * W - 2);

    typedef enum logic [1:0] {
        IDLE,
        COL,
        DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [CW-1:0]   col;
    logic [2:0]      carry;
    logic [2*W-1:0]  acc;
    logic [3:0]      s;
    logic            accept;
    logic            last_col;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_p     = acc;
    assign accept    = in_valid && (state == IDLE);
    assign last_col  = (col == COL_LAST);
    assign s         = {1'b0, cnt_sum} + {1'b0, carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = COL;
            COL:  if (last_col) next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Column k collects a[j] & b[i] for every i + j == k; at most one i matches each j.
    always_comb begin
        cnt_a = '0;
        if (state == COL) begin
            for (int i = 0; i < W; i++) begin
                for (int j = 0; j < W; j++) begin
                    if (CW'(i + j) == col) begin
                        cnt_a[j] = a[j] & b[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a     <= '0;
            b     <= '0;
            col   <= '0;
            carry <= '0;
            acc   <= '0;
        end else if (accept) begin
            a     <= in_a;
            b     <= in_b;
            col   <= '0;
            carry <= '0;
            acc   <= '0;
        end else if (state == COL) begin
            acc[col] <= s[0];
            carry    <= s[3:1];
            col      <= col + 1'b1;
            // The top product bit is the low bit of the carry left after the last column.
            if (last_col) begin
                acc[2*W-1] <= s[1];
            end
        end
    end

`ifdef MULT_COLSEQ_CHECK_EN
    function automatic logic [2:0] popcount6(input logic [5:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 6; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err <= 1'b0;
        end else if ((state == COL) && (popcount6(cnt_a) != cnt_sum)) begin
            chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_colseq_driver.sv
// tb/tb_mult_colseq_driver.sv - scoreboard bench for mult_colseq_driver with a behavioural 6:3 counter
module tb_mult_colseq_driver;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_a;
    logic [5:0]  in_b;
    logic [5:0]  cnt_a;
    logic [2:0]  cnt_sum;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_p;
    logic        chk_err;
    logic        inject;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    mult_colseq_driver #(.W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .cnt_a     (cnt_a),
        .cnt_sum   (cnt_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .chk_err   (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ones(input logic [5:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) if (v[i]) n = n + 3'd1;
        return n;
    endfunction

    // Counter model; inject adds one to the returned count.
    always_comb cnt_sum = ones(cnt_a) + {2'b00, inject};

    task automatic send_op(input logic [5:0] x, input logic [5:0] y);
        logic [11:0] p;
        p = {6'd0, x} * {6'd0, y};
        in_a = x;
        in_b = y;
        in_valid = 1'b1;
        exp_q.push_back(p);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a = $urandom_range(0, 63);
        in_b = $urandom_range(0, 63);
    endtask

    task automatic wait_valid(output int cyc, output logic [5:0] cor);
        cyc = 1;
        cor = 6'd0;
        while (!out_valid && cyc < 100) begin
            cor = cor | cnt_a;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, chk_err} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags got rdy/vld/err=%b%b%b want 100", in_ready, out_valid, chk_err);
        end
        checks++;
        if (out_p !== 12'd0 || cnt_a !== 6'd0) begin
            errors++;
            $display("FAIL reset_data got out_p=%0d cnt_a=%b want 0/0", out_p, cnt_a);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc;
        logic [5:0] cor;
        logic [11:0] e;
        out_ready = 1'b1;
        send_op(6'd63, 6'd63);
        wait_valid(cyc, cor);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 12) begin
            errors++;
            $display("FAIL latency got cycle %0d want 12", cyc);
        end
        checks++;
        if (out_p !== e || e !== 12'd3969) begin
            errors++;
            $display("FAIL prod_63x63 got %0d want %0d", out_p, e);
        end
        checks++;
        if (chk_err !== 1'b0) begin
            errors++;
            $display("FAIL chk_err_basic got %b want 0", chk_err);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL return_idle got rdy=%b vld=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_patterns;
        int cyc;
        logic [5:0] cor;
        logic [11:0] e;
        send_op(6'd45, 6'd27);
        wait_valid(cyc, cor);
        e = exp_q.pop_front();
        checks++;
        if (out_p !== e || e !== 12'd1215) begin
            errors++;
            $display("FAIL prod_45x27 got %0d want %0d", out_p, e);
        end
        @(negedge clk);
        send_op(6'd0, 6'd63);
        wait_valid(cyc, cor);
        e = exp_q.pop_front();
        checks++;
        if (out_p !== e) begin
            errors++;
            $display("FAIL prod_0x63 got %0d want %0d", out_p, e);
        end
        checks++;
        if (cor !== 6'd0) begin
            errors++;
            $display("FAIL zero_columns got cnt_a OR=%b want 000000", cor);
        end
        @(negedge clk);
    endtask

    task automatic test_stall;
        int cyc;
        int bad;
        logic [5:0] cor;
        logic [11:0] e;
        out_ready = 1'b0;
        send_op(6'd13, 6'd51);
        wait_valid(cyc, cor);
        e = exp_q.pop_front();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b1 || out_p !== e || in_ready !== 1'b0) bad++;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold got %0d bad cycles out_p=%0d want 0 bad, %0d", bad, out_p, e);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got rdy=%b vld=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_midop;
        int cyc;
        logic [5:0] cor;
        logic [11:0] e;
        send_op(6'd50, 6'd60);
        void'(exp_q.pop_back());
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || cnt_a !== 6'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_reset got vld=%b cnt_a=%b rdy=%b want 0/000000/1", out_valid, cnt_a, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_op(6'd7, 6'd9);
        wait_valid(cyc, cor);
        e = exp_q.pop_front();
        checks++;
        if (out_p !== e || e !== 12'd63) begin
            errors++;
            $display("FAIL after_reset_7x9 got %0d want %0d", out_p, e);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep;
        int cyc;
        logic [5:0] cor;
        logic [11:0] e;
        out_ready = 1'b1;
        for (int x = 0; x < 64; x++) begin
            for (int y = 0; y < 64; y++) begin
                send_op(6'(x), 6'(y));
                wait_valid(cyc, cor);
                e = exp_q.pop_front();
                checks++;
                if ({out_valid, out_p} !== {1'b1, e}) begin
                    errors++;
                    $display("FAIL sweep %0dx%0d got vld=%b p=%0d want %0d", x, y, out_valid, out_p, e);
                end
                @(negedge clk);
            end
        end
        checks++;
        if (chk_err !== 1'b0) begin
            errors++;
            $display("FAIL sweep_chk_err got %b want 0", chk_err);
        end
    endtask

`ifdef MULT_COLSEQ_CHECK_EN
    task automatic test_checker;
        int cyc;
        logic [5:0] cor;
        out_ready = 1'b1;
        send_op(6'd63, 6'd63);
        repeat (3) @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        checks++;
        if (chk_err !== 1'b1) begin
            errors++;
            $display("FAIL chk_set got %b want 1", chk_err);
        end
        wait_valid(cyc, cor);
        void'(exp_q.pop_front());
        @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (chk_err !== 1'b1) begin
            errors++;
            $display("FAIL chk_sticky got %b want 1", chk_err);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (chk_err !== 1'b0) begin
            errors++;
            $display("FAIL chk_clear got %b want 0", chk_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = 6'd0;
        in_b = 6'd0;
        out_ready = 1'b0;
        inject = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_patterns;
        test_stall;
        test_reset_midop;
`ifdef MULT_COLSEQ_CHECK_EN
        test_checker;
`endif
        test_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_colseq_driver.md
# mult_colseq_driver

Sequential column-serial unsigned multiplier controller that acts as the driving end of the 6-input column counter interface (A1..A6 in, {CO,S2,S1} 3-bit count out) used by the team's Wallace compressor cells. It accepts two W-bit operands, forms the partial-product bits of one column per cycle, presents them to an external 6:3 counter, and accumulates the returned counts with a running carry to produce the 2W-bit product. It sits between an operand source and result sink using valid/ready handshakes; the counter instance is outside this block.

## Interface
- W, 6, operand width; legal 2..6 (column height ≤ W ≤ 6 counter inputs)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- in_a  in  W  multiplicand, unsigned
- in_b  in  W  multiplier, unsigned
- cnt_a  out  6  column bits to counter; cnt_a[5] drives A1 … cnt_a[0] drives A6
- cnt_sum  in  3  counter result {CO,S2,S1}, combinational from cnt_a, value 0..6
- out_valid  out  1  product valid
- out_ready  in  1  sink accepts product
- out_p  out  2W  product
- chk_err  out  1  sticky counter-mismatch flag (see Configuration)

## Operation
- States: IDLE, COL, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: register a=in_a, b=in_b, col=0, carry=0, acc=0; go COL.
- COL (column k=col, 0..2W-2): cnt_a[j] = a[j] & b[k-j] for j with 0≤j<W and 0≤k-j<W, else 0; unused upper bits 0. Sampled at edge: s = cnt_sum + carry (4-bit, max 12); acc[k] ← s[0]; carry ← s[3:1] (3-bit, bounded ≤6).
- After k=2W-2: acc[2W-1] ← bit 0 of the new carry (carry's upper bits are 0 for a valid counter); go DONE.
- DONE: out_valid=1, out_p=acc held stable. On out_ready: go IDLE. No operand accepted in the same cycle as the DONE→IDLE transition.
- cnt_a = 0 in IDLE and DONE.
- Arithmetic: unsigned only; out_p = in_a*in_b exactly for W≤6.
- Counter results are trusted; out-of-range cnt_sum (7) is added as-is.

## Timing
- Reset (async assert, sync-to-clk deassert by upstream): state=IDLE, in_ready=1, out_valid=0, out_p=0, cnt_a=0, chk_err=0, carry=0, col=0.
- Latency: accept edge → 2W-1 COL cycles → out_valid high in cycle 2W after accept edge (W=6: cycle 12).
- Throughput: one product per 2W+1 cycles minimum (accept, 2W-1 columns, one DONE cycle).
- out_valid/out_p stay asserted and unchanged while out_ready=0 (unbounded stall).
- in_valid ignored outside IDLE; in_a/in_b may change freely after accept.
- Reset mid-COL or mid-DONE: operation discarded, outputs to reset values immediately; no partial result emitted.
- cnt_sum must settle within the same cycle cnt_a is driven (combinational counter, single-cycle path).

## Configuration
- MULT_COLSEQ_CHECK_EN defined: block computes internal popcount of cnt_a each COL cycle; if it differs from cnt_sum, chk_err set at that edge and held until reset. Result still uses cnt_sum.
- Not defined: no checker logic; chk_err tied 0.

## Test plan
- W=6, in_a=63, in_b=63, out_ready=1 -> out_valid at cycle 12 after accept, out_p=3969, chk_err=0.
- in_a=45, in_b=27 -> out_p=1215; in_a=0, in_b=63 -> out_p=0 with cnt_a=0 in every COL cycle.
- out_ready held 0 for 20 cycles after out_valid -> out_p stable at product, in_ready=0 throughout; release -> IDLE next cycle, in_ready=1.
- rst_n pulsed low at COL column 5 -> out_valid=0, cnt_a=0, in_ready=1 immediately; next operands 7*9 -> out_p=63.
- Exhaustive 64×64 operand sweep with correct counter model -> every out_p = a*b, chk_err=0.
- With MULT_COLSEQ_CHECK_EN, counter model forced to return popcount+1 on column 3 -> chk_err=1 after that edge and stays 1 until reset.
